mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single 24-bit memory port (8-bit MAR, data in/out, EN, CS) between two requesters: the CPU and a DMA/loader port used to preload and inspect memory. It serialises accesses, drives the memory's CS/EN/MAR/data lines for a fixed access window, and returns read data with a one-cycle acknowledge. It sits between `CPU`/loader and `MEMORY` in the top-level bench.

## Interface
- `ADDR_W`, 8, address width (MAR width)
- `DATA_W`, 24, memory word width
- `MEM_LAT`, 2, clock cycles CS is held per access; legal range 1..15

- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  CPU access request, level, held until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  CPU read data
- `cpu_ack`  out  1  one-cycle completion pulse
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ack`: same widths and meaning for the DMA port
- `mem_addr`  out  ADDR_W  to memory MAR
- `mem_wdata`  out  DATA_W  to memory data-in
- `mem_rdata`  in  DATA_W  from memory data-out
- `mem_en`  out  1  memory write enable (1 = write)
- `mem_cs`  out  1  memory chip select
- `owner`  out  1  0 = CPU, 1 = DMA; port of current/last grant
- `busy`  out  1  high whenever state is not IDLE

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, ACCESS, RELEASE.
- IDLE: if any `req` sampled high at a rising edge, pick winner (see Configuration), latch its we/addr/wdata into `mem_en`/`mem_addr`/`mem_wdata`, set `owner`, `mem_cs`=1, counter=MEM_LAT-1, go ACCESS.
- ACCESS: counter decrements each edge; on the edge where counter==0: if read, capture `mem_rdata` into owner's rdata register; `mem_cs`=0, `mem_en`=0, owner's ack=1, go RELEASE.
- RELEASE: ack=0, go IDLE. Unconditional; gives one dead cycle between accesses.
- Requester operands must be stable from req assertion until ack; the arbiter latches them at grant anyway.
- `*_rdata` holds its value until the next read completes on that port; writes leave it unchanged.
- `mem_en` is never high while `mem_cs` is low.
- Loser's request simply waits; no request is dropped.
- Reset values: `mem_cs`=0, `mem_en`=0, `mem_addr`=0, `mem_wdata`=0, both rdata=0, both ack=0, `owner`=0, `busy`=0, state IDLE, last-served=DMA.
- Reset asserted mid-access: transaction aborted immediately, no ack issued, all outputs to reset values.

## Timing
- Request sampled at edge E0 → `mem_cs` high from E0 to E0+MEM_LAT → ack high from E0+MEM_LAT to E0+MEM_LAT+1.
- Read data valid in `*_rdata` in the ack cycle; total latency MEM_LAT+1 edges to ack.
- Next grant at earliest at edge E0+MEM_LAT+2; access pitch MEM_LAT+2 cycles.
- Requester must deassert req by edge E0+MEM_LAT+2; req still high there is a new transaction.
- MEM_LAT=1: CS high for exactly one cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests in IDLE, port not served last wins; last-served updates at each grant; after reset CPU wins first.
- Undefined: fixed priority, CPU always wins on simultaneous requests; DMA can be starved by continuous CPU traffic.

## Test plan
- Reset, then CPU write addr 4 data 96, MEM_LAT=2 → `mem_cs` high 2 cycles with `mem_en`=1, `mem_addr`=4, `cpu_ack` pulse at E0+2; read back addr 4 → `cpu_rdata`=96 at ack.
- DMA write addr 10 data 0xABCDEF, then CPU read addr 10 → `cpu_rdata`=0xABCDEF, `dma_rdata` unchanged 0.
- Both req high together, held for 4 transactions: without macro → CPU, CPU, CPU, CPU; with macro → CPU, DMA, CPU, DMA; `owner` matches each grant.
- CPU keeps req high after ack → second access starts exactly at E0+MEM_LAT+2; one dead cycle with `mem_cs`=0 between accesses.
- `reset_n` low at E0+1 during DMA write → `mem_cs`/`mem_en` drop immediately, no `dma_ack`, `busy`=0; after release, pending request regranted normally.
- MEM_LAT=1 read of addr 255 → `mem_cs` high one cycle, ack at E0+1, address does not wrap or truncate.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters (CPU, DMA/loader) and the memory.
// slave = arbiter side, master = requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_en;
    logic              mem_cs;

    logic              owner;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_addr, mem_wdata, mem_en, mem_cs,
        input  mem_rdata,
        output owner, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_addr, mem_wdata, mem_en, mem_cs,
        output mem_rdata,
        input  owner, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter for a single memory port with a fixed MEM_LAT-cycle access window.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the CPU has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 24,
    parameter int MEM_LAT = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic                     grant, done, win_dma;
    logic                     sel_we;
    logic [ADDR_W-1:0]        sel_addr;
    logic [DATA_W-1:0]        sel_wdata;
    logic [1:0][DATA_W-1:0]   rdata;   // [0] = CPU, [1] = DMA
    logic [1:0]               ack;
    logic                     owner;
    logic                     mem_cs, mem_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                     last_dma;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done      = 1'b0;
        win_dma   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    // On a tie, the port not served last wins.
                    win_dma = bus.dma_req && (!bus.cpu_req || !last_dma);
`else
                    win_dma = !bus.cpu_req;
`endif
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign sel_we    = win_dma ? bus.dma_we    : bus.cpu_we;
    assign sel_addr  = win_dma ? bus.dma_addr  : bus.cpu_addr;
    assign sel_wdata = win_dma ? bus.dma_wdata : bus.cpu_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            rdata     <= '0;
            ack       <= '0;
            owner     <= 1'b0;
            mem_cs    <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_dma  <= 1'b1;
`endif
        end else begin
            ack <= '0;
            if (grant) begin
                owner     <= win_dma;
                mem_cs    <= 1'b1;
                mem_en    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                cnt       <= CNT_W'(MEM_LAT - 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_dma  <= win_dma;
`endif
            end else if (state == ACCESS) begin
                if (done) begin
                    // mem_en still holds the latched write flag here
                    if (!mem_en) rdata[owner] <= bus.mem_rdata;
                    ack[owner] <= 1'b1;
                    mem_cs     <= 1'b0;
                    mem_en     <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign bus.cpu_rdata = rdata[0];
    assign bus.dma_rdata = rdata[1];
    assign bus.cpu_ack   = ack[0];
    assign bus.dma_ack   = ack[1];
    assign bus.owner     = owner;
    assign bus.busy      = (state != IDLE);
    assign bus.mem_cs    = mem_cs;
    assign bus.mem_en    = mem_en;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts grants, bus timing and read data.
// A second instance with MEM_LAT=1 covers the single-cycle access window.
module tb_mem_arbiter;
    localparam int LAT = 2;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [23:0] data;
    } op_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic mem_clr = 1'b1;
    always #5 clock = ~clock;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(24)) b();
    mem_arbiter_if #(.ADDR_W(8), .DATA_W(24)) b1();

    mem_arbiter #(.ADDR_W(8), .DATA_W(24), .MEM_LAT(LAT)) dut (
        .clock(clock), .reset_n(reset_n), .bus(b));
    mem_arbiter #(.ADDR_W(8), .DATA_W(24), .MEM_LAT(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(b1));

    function automatic logic [23:0] init_val(int i);
        return 24'(i * 37 + 256);
    endfunction

    // memory devices
    logic [23:0] mem_arr  [256];
    logic [23:0] mem1_arr [256];
    assign b.mem_rdata  = mem_arr[b.mem_addr];
    assign b1.mem_rdata = mem1_arr[b1.mem_addr];
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem_arr[i]  <= init_val(i);
                mem1_arr[i] <= init_val(i);
            end
        end else begin
            if (b.mem_cs && b.mem_en)   mem_arr[b.mem_addr]   <= b.mem_wdata;
            if (b1.mem_cs && b1.mem_en) mem1_arr[b1.mem_addr] <= b1.mem_wdata;
        end
    end

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d got %0h exp %0h", tag, cyc, got, exp);
        end
    endtask

    // reference model: one transaction at a time, timed from its grant cycle
    logic [23:0] ref_mem [256];
    logic [23:0] exp_rd  [2];
    bit          have_g;
    int          g;
    int          next_free;
    bit          t_port;
    op_t         t_op;
    bit          last_dma;

    op_t qc[$];
    op_t qd[$];
    int  go_pct;
    bit  own_log[$];

    function automatic op_t mk(logic we, logic [7:0] addr, logic [23:0] data);
        op_t o;
        o.we = we; o.addr = addr; o.data = data;
        return o;
    endfunction

    task automatic model_reset();
        have_g = 1'b0; g = 0; next_free = 0; t_port = 1'b0; t_op = '0;
        last_dma = 1'b1; exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    task automatic chk_rst();
        chk("rst_cs",    b.mem_cs,    0);
        chk("rst_en",    b.mem_en,    0);
        chk("rst_addr",  b.mem_addr,  0);
        chk("rst_wdata", b.mem_wdata, 0);
        chk("rst_owner", b.owner,     0);
        chk("rst_busy",  b.busy,      0);
        chk("rst_cack",  b.cpu_ack,   0);
        chk("rst_dack",  b.dma_ack,   0);
        chk("rst_crd",   b.cpu_rdata, 0);
        chk("rst_drd",   b.dma_rdata, 0);
    endtask

    task automatic drive();
        if (!b.cpu_req && qc.size() > 0 && $urandom_range(0, 99) < go_pct) begin
            b.cpu_req = 1'b1; b.cpu_we = qc[0].we; b.cpu_addr = qc[0].addr; b.cpu_wdata = qc[0].data;
        end
        if (!b.dma_req && qd.size() > 0 && $urandom_range(0, 99) < go_pct) begin
            b.dma_req = 1'b1; b.dma_we = qd[0].we; b.dma_addr = qd[0].addr; b.dma_wdata = qd[0].data;
        end
    endtask

    task automatic step();
        logic rq_c, rq_d, w, cs_e, ack_e;
        op_t  oc, od;
        rq_c = b.cpu_req; rq_d = b.dma_req;
        oc = mk(b.cpu_we, b.cpu_addr, b.cpu_wdata);
        od = mk(b.dma_we, b.dma_addr, b.dma_wdata);
        @(posedge clock); #1; cyc++;
        if (cyc >= next_free && (rq_c || rq_d)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w = (rq_c && rq_d) ? !last_dma : rq_d;
`else
            w = !rq_c;
`endif
            last_dma = w;
            have_g = 1'b1; g = cyc; t_port = w; t_op = w ? od : oc;
            next_free = cyc + LAT + 2;
        end
        ack_e = have_g && (cyc == g + LAT);
        if (ack_e) begin
            if (t_op.we) ref_mem[t_op.addr] = t_op.data;
            else         exp_rd[t_port] = ref_mem[t_op.addr];
        end
        cs_e = have_g && (cyc < g + LAT);
        chk("mem_cs",    b.mem_cs,    cs_e);
        chk("mem_en",    b.mem_en,    cs_e && t_op.we);
        chk("mem_addr",  b.mem_addr,  have_g ? t_op.addr : 8'd0);
        chk("mem_wdata", b.mem_wdata, have_g ? t_op.data : 24'd0);
        chk("owner",     b.owner,     have_g ? t_port : 1'b0);
        chk("busy",      b.busy,      have_g && (cyc <= g + LAT));
        chk("cpu_ack",   b.cpu_ack,   ack_e && !t_port);
        chk("dma_ack",   b.dma_ack,   ack_e && t_port);
        chk("cpu_rdata", b.cpu_rdata, exp_rd[0]);
        chk("dma_rdata", b.dma_rdata, exp_rd[1]);
        if (b.cpu_ack || b.dma_ack) own_log.push_back(b.owner);
        if (ack_e) begin
            if (!t_port) begin void'(qc.pop_front()); b.cpu_req = 1'b0; end
            else         begin void'(qd.pop_front()); b.dma_req = 1'b0; end
        end
        drive();
    endtask

    task automatic run(int budget);
        int n = 0;
        drive();
        while ((qc.size() > 0 || qd.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (qc.size() > 0 || qd.size() > 0) chk("timeout", qc.size() + qd.size(), 0);
        repeat (LAT + 2) step();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        b.cpu_req = 1'b0; b.dma_req = 1'b0;
        qc.delete(); qd.delete();
        model_reset();
        repeat (2) begin @(posedge clock); cyc++; end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        b.cpu_req = 0; b.cpu_we = 0; b.cpu_addr = 0; b.cpu_wdata = 0;
        b.dma_req = 0; b.dma_we = 0; b.dma_addr = 0; b.dma_wdata = 0;
        b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
        b1.dma_req = 0; b1.dma_we = 0; b1.dma_addr = 0; b1.dma_wdata = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        model_reset();
        go_pct = 100;

        // reset values
        @(posedge clock); #1; cyc++;
        mem_clr = 1'b0;
        chk_rst();
        @(negedge clock);
        reset_n = 1'b1;

        // CPU write then read back
        qc.push_back(mk(1'b1, 8'd4, 24'd96));
        qc.push_back(mk(1'b0, 8'd4, 24'h5a5a5a));
        run(40);
        chk("rd_addr4", b.cpu_rdata, 24'd96);

        // DMA preload, CPU inspects
        qd.push_back(mk(1'b1, 8'd10, 24'habcdef));
        run(40);
        qc.push_back(mk(1'b0, 8'd10, 24'd0));
        run(40);
        chk("rd_addr10", b.cpu_rdata, 24'habcdef);
        chk("dma_rd_kept", b.dma_rdata, 24'd0);

        // simultaneous continuous requests: grant order
        do_reset();
        own_log.delete();
        for (int i = 0; i < 4; i++) begin
            qc.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 24'($urandom)));
            qd.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 24'($urandom)));
        end
        run(100);
        chk("grant_cnt", own_log.size(), 8);
        if (own_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                chk("grant_order", own_log[i], i % 2);
`else
                chk("grant_order", own_log[i], 0);
`endif
            end
        end

        // reset in the middle of a DMA write
        do_reset();
        qd.push_back(mk(1'b1, 8'd77, 24'h123456));
        drive();
        n = 0;
        while (!(have_g && t_port) && n < 20) begin step(); n++; end
        chk("abort_grant", have_g && t_port, 1);
        step();
        #1 reset_n = 1'b0;
        #1 chk_rst();
        model_reset();
        repeat (2) begin @(posedge clock); cyc++; end
        @(negedge clock);
        reset_n = 1'b1;
        run(40);

        // MEM_LAT=1 read of the top address
        @(negedge clock);
        b1.cpu_we = 1'b0; b1.cpu_addr = 8'd255; b1.cpu_wdata = 24'd0; b1.cpu_req = 1'b1;
        @(posedge clock); #1;
        chk("l1_cs",   b1.mem_cs,   1);
        chk("l1_addr", b1.mem_addr, 255);
        chk("l1_ack0", b1.cpu_ack,  0);
        b1.cpu_req = 1'b0;
        @(posedge clock); #1;
        chk("l1_cs_off", b1.mem_cs,    0);
        chk("l1_ack",    b1.cpu_ack,   1);
        chk("l1_rdata",  b1.cpu_rdata, init_val(255));
        @(posedge clock); #1;
        chk("l1_ack_off", b1.cpu_ack, 0);
        chk("l1_busy",    b1.busy,    0);

        // random mixed traffic, small address window for read-after-write hits
        do_reset();
        go_pct = 40;
        for (int i = 0; i < 30; i++) begin
            qc.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 24'($urandom)));
            qd.push_back(mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 24'($urandom)));
        end
        run(2000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
